mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the MIPS core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback states, one state per clock. It supports the same opcode set as the single-cycle decoder: RTYPE, LW, SW, BEQ, ADDI, J, XORI, LUI, BGTZ and LI. It sits beside the datapath and drives every mux select and write enable; the ALU decoder consumes its `aluop`.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from the instruction register, stable from DECODE onward.
- `memready` in 1: memory access complete (used only with MC_CTRL_MEMWAIT_EN).
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite`, `pcwrite`, `memwrite`, `regwrite` out 1 each: write enables.
- `regdst`, `memtoreg`, `alusrca` out 1 each: datapath selects.
- `alusrcb` out 2: 00 = reg B, 01 = const 4, 10 = extended imm, 11 = extended imm << 2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = subtract, 10 = use funct, 11 = op-specific.
- `immext` out 2: 00 = sign-extend, 01 = zero-extend, 10 = imm << 16.
- `branch` out 1: conditional PC write.
- `brtype` out 1: branch condition; 0 = zero (BEQ), 1 = greater than zero (BGTZ).
- `illegal` out 1: sticky undefined-opcode flag.

## Operation
- Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, IEX, IWB, BRANCH, JUMP, TRAP.
- All outputs not listed for a state are 0.
- FETCH: `irwrite=1`, `pcwrite=1`, `alusrcb=01`. Next state is DECODE.
- DECODE: `alusrcb=11`, `aluop=00`; this precomputes the branch target. Next state by `op`:
  - LW/SW → MEMADR
  - RTYPE → RTYPEEX
  - ADDI/XORI/LUI/LI → IEX
  - BEQ/BGTZ → BRANCH
  - J → JUMP
  - any other opcode → TRAP
- MEMADR: `alusrca=1`, `alusrcb=10`. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: `iord=1`, then MEMWB. MEMWB: `memtoreg=1`, `regwrite=1`, then FETCH.
- MEMWR: `iord=1`, `memwrite=1`, then FETCH.
- RTYPEEX: `alusrca=1`, `aluop=10`, then ALUWB. ALUWB: `regdst=1`, `regwrite=1`, then FETCH.
- IEX: `alusrca=1`, `alusrcb=10`, then IWB. Per-opcode settings:
  - ADDI: `aluop=00`, `immext=00`
  - XORI: `aluop=11`, `immext=01`
  - LUI: `aluop=11`, `immext=10`
  - LI: `aluop=11`, `immext=00`
- IWB: `regwrite=1`, `regdst=0`, then FETCH.
- BRANCH: `alusrca=1`, `aluop=01`, `pcsrc=01`, `branch=1`, `brtype=(op==BGTZ)`, then FETCH.
- JUMP: `pcsrc=10`, `pcwrite=1`, then FETCH.
- TRAP: absorbing. `illegal=1`, all enables 0, leaves only on reset.

## Timing
- Instruction latency in cycles, FETCH included: LW 5; SW, RTYPE and I-ALU 4; BEQ, BGTZ and J 3.
- Reset low forces state to FETCH and `illegal` to 0 immediately.
- While reset is low, `irwrite`, `pcwrite`, `memwrite` and `regwrite` are forced to 0 combinationally. All other outputs take their FETCH values.
- First FETCH writes occur at the first rising edge after reset deasserts.
- Reset mid-instruction aborts it; no partial writeback completes after reset asserts.
- IEX and BRANCH outputs depend on `op`. `op` is only sampled in DECODE and later, never in FETCH.

## Configuration
- `MC_CTRL_MEMWAIT_EN` defined: FETCH, MEMRD and MEMWR hold state until `memready=1`.
  - In FETCH, `irwrite` and `pcwrite` are asserted only in the `memready` cycle.
  - In MEMWR, `memwrite` stays asserted for every cycle of the hold.
  - Each wait cycle adds exactly one cycle of latency.
- Undefined: `memready` is ignored and each memory state lasts exactly one cycle.

## Structure
- Package `mc_pkg` holds:
  - opcode localparams (RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, XORI 001110, LUI 001111, BGTZ 000111, LI 010001)
  - the `state_t` enum
  - encodings for `alusrcb`, `pcsrc`, `aluop` and `immext`
- Sub-module `mc_outdec` is a combinational decoder from state and `op` to the control word.
- `mc_controller` keeps the state register, next-state logic, the `illegal` flop and reset gating.

## Test plan
- LW (op=100011) after reset: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite=1` and `memtoreg=1` in cycle 5 only; next FETCH in cycle 6.
- SW (op=101011): `memwrite=1` and `iord=1` in cycle 4 only; `regwrite` stays 0 throughout.
- LUI (op=001111): in IEX, `aluop=11`, `immext=10`, `alusrcb=10`. XORI (op=001110): `immext=01`.
- BGTZ (op=000111): in BRANCH, `brtype=1`, `branch=1`, `pcsrc=01`. For BEQ: `brtype=0`.
- op=111111: TRAP entered after DECODE, `illegal=1` held for 10+ cycles. Reset low clears it and returns to FETCH.
- With MC_CTRL_MEMWAIT_EN and `memready` held low 3 cycles in FETCH: state stays FETCH and `irwrite=0` for those 3 cycles. The cycle `memready` rises, `irwrite=1` and `pcwrite=1`. Reset asserted during MEMRD gives no `regwrite` pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM states, select encodings and control word for the multicycle MIPS controller
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_LI    = 6'b010001;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    ALUWB, IEX, IWB, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OP    = 2'b11;

  localparam logic [1:0] IMM_SIGN = 2'b00;
  localparam logic [1:0] IMM_ZERO = 2'b01;
  localparam logic [1:0] IMM_LUI  = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [1:0] immext;
    logic       branch;
    logic       brtype;
  } ctrl_t;
endpackage

// File: rtl/mc_controller_outdec.sv
// mc_outdec: Moore output decoder from FSM state (and op for IEX/BRANCH) to the control word
module mc_outdec
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  output ctrl_t       ctrl
);
  // one control word per state; anything not set stays 0 (TRAP included)
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      IEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_OP;
        ctrl.immext  = (op == OP_XORI) ? IMM_ZERO : (op == OP_LUI) ? IMM_LUI : IMM_SIGN;
      end
      IWB: ctrl.regwrite = 1'b1;
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        ctrl.brtype  = (op == OP_BGTZ);
      end
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM; define MC_CTRL_MEMWAIT_EN to stall memory states on memready
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [1:0] immext,
  output logic       branch,
  output logic       brtype,
  output logic       illegal
);
  state_t state, state_nx;
  ctrl_t  ctrl;
  logic   mem_ok;
  logic   illegal_q;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ok = memready;
`else
  logic unused_memready;
  assign unused_memready = memready;
  assign mem_ok = 1'b1;
`endif

  mc_outdec u_outdec (
    .state (state),
    .op    (op),
    .ctrl  (ctrl)
  );

  // next state; memory states advance only when the access completes
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = mem_ok ? DECODE : FETCH;
      DECODE:  state_nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_RTYPE) ? RTYPEEX :
                          (op == OP_ADDI || op == OP_XORI || op == OP_LUI || op == OP_LI) ? IEX :
                          (op == OP_BEQ || op == OP_BGTZ) ? BRANCH :
                          (op == OP_J) ? JUMP : TRAP;
      MEMADR:  state_nx = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_nx = mem_ok ? MEMWB : MEMRD;
      MEMWR:   state_nx = mem_ok ? FETCH : MEMWR;
      RTYPEEX: state_nx = ALUWB;
      IEX:     state_nx = IWB;
      TRAP:    state_nx = TRAP;
      default: state_nx = FETCH;
    endcase
  end

  // state register and sticky illegal flag, both cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= illegal_q | (state_nx == TRAP);
    end
  end

  // write enables are masked while reset is held so nothing commits during reset;
  // fetch writes wait for the memory to deliver the instruction
  assign irwrite  = ctrl.irwrite & reset & mem_ok;
  assign pcwrite  = ctrl.pcwrite & reset & ((state != FETCH) | mem_ok);
  assign memwrite = ctrl.memwrite & reset;
  assign regwrite = ctrl.regwrite & reset;
  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign immext   = ctrl.immext;
  assign branch   = ctrl.branch;
  assign brtype   = ctrl.brtype;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven, scoreboarded bench for mc_controller (MC_CTRL_MEMWAIT_EN adds stall sequences)
module tb_mc_controller;
  typedef logic [18:0] ov_t;
  typedef struct {
    string            name;
    logic [5:0]       op;
    int               n;
    logic [0:4][18:0] exp;
  } vec_t;

  // {iord,irwrite,pcwrite,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop,immext,branch,brtype,illegal}
  localparam ov_t Z   = 19'b0;
  localparam ov_t F   = 19'b0_1_1_0_0_0_0_0_01_00_00_00_0_0_0;
  localparam ov_t RST = 19'b0_0_0_0_0_0_0_0_01_00_00_00_0_0_0;
  localparam ov_t D   = 19'b0_0_0_0_0_0_0_0_11_00_00_00_0_0_0;
  localparam ov_t MA  = 19'b0_0_0_0_0_0_0_1_10_00_00_00_0_0_0;
  localparam ov_t MR  = 19'b1_0_0_0_0_0_0_0_00_00_00_00_0_0_0;
  localparam ov_t MB  = 19'b0_0_0_0_1_0_1_0_00_00_00_00_0_0_0;
  localparam ov_t MWR = 19'b1_0_0_1_0_0_0_0_00_00_00_00_0_0_0;
  localparam ov_t RX  = 19'b0_0_0_0_0_0_0_1_00_00_10_00_0_0_0;
  localparam ov_t AW  = 19'b0_0_0_0_1_1_0_0_00_00_00_00_0_0_0;
  localparam ov_t IXA = 19'b0_0_0_0_0_0_0_1_10_00_00_00_0_0_0;
  localparam ov_t IXX = 19'b0_0_0_0_0_0_0_1_10_00_11_01_0_0_0;
  localparam ov_t IXU = 19'b0_0_0_0_0_0_0_1_10_00_11_10_0_0_0;
  localparam ov_t IXL = 19'b0_0_0_0_0_0_0_1_10_00_11_00_0_0_0;
  localparam ov_t IW  = 19'b0_0_0_0_1_0_0_0_00_00_00_00_0_0_0;
  localparam ov_t BRE = 19'b0_0_0_0_0_0_0_1_00_01_01_00_1_0_0;
  localparam ov_t BRG = 19'b0_0_0_0_0_0_0_1_00_01_01_00_1_1_0;
  localparam ov_t JP  = 19'b0_0_1_0_0_0_0_0_00_10_00_00_0_0_0;
  localparam ov_t TR  = 19'b0_0_0_0_0_0_0_0_00_00_00_00_0_0_1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memready = 1'b0;
  logic [5:0] op = 6'b111111;
  logic       iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop, immext;
  logic       branch, brtype, illegal;
  ov_t        outv;
  ov_t        sb[$];
  vec_t       tbl[10];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .memready (memready),
    .iord     (iord),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .immext   (immext),
    .branch   (branch),
    .brtype   (brtype),
    .illegal  (illegal)
  );

  assign outv = {iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, aluop, immext, branch, brtype, illegal};

  task automatic check(input string nm, input ov_t got, input ov_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, got, exp);
    end
  endtask

  // Enters with the DUT in FETCH and op still garbage; op becomes valid only from DECODE.
  task automatic run_instr(input vec_t v);
    ov_t e;
    for (int c = 0; c < v.n; c++) sb.push_back(v.exp[c]);
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s_c%0d", v.name, c + 1), outv, e);
      if (c == 0) op = v.op;
    end
    @(posedge clk);
    #1 op = 6'b111111;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{"RTYPE", 6'b000000, 4, {F, D, RX, AW, Z}};
    tbl[1] = '{"LW",    6'b100011, 5, {F, D, MA, MR, MB}};
    tbl[2] = '{"SW",    6'b101011, 4, {F, D, MA, MWR, Z}};
    tbl[3] = '{"BEQ",   6'b000100, 3, {F, D, BRE, Z, Z}};
    tbl[4] = '{"ADDI",  6'b001000, 4, {F, D, IXA, IW, Z}};
    tbl[5] = '{"J",     6'b000010, 3, {F, D, JP, Z, Z}};
    tbl[6] = '{"XORI",  6'b001110, 4, {F, D, IXX, IW, Z}};
    tbl[7] = '{"LUI",   6'b001111, 4, {F, D, IXU, IW, Z}};
    tbl[8] = '{"BGTZ",  6'b000111, 3, {F, D, BRG, Z, Z}};
    tbl[9] = '{"LI",    6'b010001, 4, {F, D, IXL, IW, Z}};
`ifdef MC_CTRL_MEMWAIT_EN
    memready = 1'b1;
`else
    memready = 1'b0;
`endif
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", outv, RST);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) run_instr(tbl[i]);
    run_instr(tbl[1]);

    // undefined opcode: trap after DECODE, sticky illegal, async clear
    @(negedge clk);
    check("trap_fetch", outv, F);
    op = 6'b111111;
    @(negedge clk);
    check("trap_decode", outv, D);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("trap_hold%0d", i), outv, TR);
    end
    #2 reset = 1'b0;
    #1 check("trap_reset_async", outv, RST);
    @(posedge clk);
    #1 check("trap_reset_edge", outv, RST);
    reset = 1'b1;
    run_instr(tbl[0]);

    // reset in MEMRD: no writeback pulse afterwards
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lw_abort_c%0d", c + 1), outv, tbl[1].exp[c]);
      if (c == 0) op = 6'b100011;
    end
    #2 reset = 1'b0;
    #1 check("lw_abort_async", outv, RST);
    @(posedge clk);
    #1 check("lw_abort_edge", outv, RST);
    @(negedge clk);
    check("lw_abort_mid", outv, RST);
    @(posedge clk);
    #1 reset = 1'b1;
    op = 6'b111111;
    run_instr(tbl[4]);

`ifdef MC_CTRL_MEMWAIT_EN
    // fetch stalled three cycles, then SW with a three-cycle MEMWR
    memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("wait_fetch%0d", i), outv, RST);
      @(posedge clk);
      #1;
    end
    memready = 1'b1;
    @(negedge clk);
    check("fetch_ready", outv, F);
    op = 6'b101011;
    @(negedge clk);
    check("wsw_decode", outv, D);
    @(negedge clk);
    check("wsw_memadr", outv, MA);
    memready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("wsw_hold%0d", i), outv, MWR);
    end
    @(posedge clk);
    #1 memready = 1'b1;
    @(negedge clk);
    check("wsw_done", outv, MWR);
    @(posedge clk);
    #1 op = 6'b111111;
    // LW stalled in MEMRD then reset: no regwrite
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wlw_c%0d", c + 1), outv, tbl[1].exp[c]);
      if (c == 0) op = 6'b100011;
      if (c == 2) memready = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("wlw_memrd%0d", i), outv, MR);
    end
    #2 reset = 1'b0;
    memready = 1'b1;
    #1 check("wlw_reset", outv, RST);
    @(posedge clk);
    #1 check("wlw_reset_edge", outv, RST);
    reset = 1'b1;
    op = 6'b111111;
    run_instr(tbl[2]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
